// File: rtl/synth_pkg.sv
// Shared types for the oscillator wave-mode controller.
package synth_pkg;

  typedef enum logic [1:0] {WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_SINE} wave_t;
  typedef enum logic [1:0] {IDLE, FADE, UPDATE, SETTLE} wmc_state_t;

  // 2-bit wrap: SINE advances back to SQUARE.
  function automatic wave_t next_wave(input wave_t w);
    logic [1:0] v;
    v = w + 2'd1;
    return wave_t'(v);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises a raw push-button, debounces it, and emits one pulse per clean press.
module key_debounce
  import synth_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   w_key;

  assign w_key     = r_sync[SYNC_STAGES-1];
  assign key_level = r_level;
  assign press     = r_press;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], key_raw};
      r_press <= 1'b0;
      if (w_key == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= TERM) begin
        // Press pulse lines up with the debounced level rising; release is silent.
        r_level <= w_key;
        r_cnt   <= '0;
        r_press <= w_key;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_mode_ctrl.sv
// Click-free wave-type switching: mute, wait for zero crossing, switch, settle, unmute.
module wave_mode_ctrl
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int SETTLE_CYCLES   = 256
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       mode_key_raw,
  input  logic       zero_cross,
  output logic [1:0] wave_sel,
  output logic       mute,
  output logic       cfg_strobe,
  output logic       busy
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int            SW      = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] ST_TERM = SW'(SETTLE_CYCLES - 1);

  wmc_state_t    r_state, w_next;
  wave_t         r_wave;
  logic [TW-1:0] r_fade_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic          r_pending, r_mute, r_strobe;
  logic          w_press, w_unused_key_level, w_clr_pend;

  key_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk      (clk),
    .n_rst    (n_rst),
    .key_raw  (mode_key_raw),
    .key_level(w_unused_key_level),
    .press    (w_press)
  );

  always_comb begin
    w_next     = r_state;
    w_clr_pend = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press || r_pending) w_next = FADE;
        w_clr_pend = r_pending;
      end
      FADE:   if (zero_cross || r_fade_cnt == TO_TERM) w_next = UPDATE;
      UPDATE: w_next = SETTLE;
      SETTLE: begin
        if (r_settle_cnt == ST_TERM) begin
          // A queued press chains straight into the next fade, keeping mute high.
          w_next     = r_pending ? FADE : IDLE;
          w_clr_pend = r_pending;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_wave       <= WAVE_SQUARE;
      r_fade_cnt   <= '0;
      r_settle_cnt <= '0;
      r_pending    <= 1'b0;
      r_mute       <= 1'b0;
      r_strobe     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mute   <= (w_next != IDLE);
      r_strobe <= (r_state == UPDATE);
      if (r_state == UPDATE) r_wave <= next_wave(r_wave);

      if (r_state == FADE) r_fade_cnt <= (r_fade_cnt == TO_TERM) ? r_fade_cnt : r_fade_cnt + 1'b1;
      else                 r_fade_cnt <= '0;
      if (r_state == SETTLE) r_settle_cnt <= (r_settle_cnt == ST_TERM) ? r_settle_cnt : r_settle_cnt + 1'b1;
      else                   r_settle_cnt <= '0;

      // Set wins over consume so a press on the consuming cycle stays queued.
      if (w_press && r_state != IDLE) r_pending <= 1'b1;
      else if (w_clr_pend)            r_pending <= 1'b0;
    end
  end

  assign wave_sel   = r_wave;
  assign mute       = r_mute;
  assign busy       = r_mute;
  assign cfg_strobe = r_strobe;

endmodule

// File: tb/tb_wave_mode_ctrl.sv
// Directed bench for wave_mode_ctrl; a second instance with a long timeout exercises the 1-deep queue.
module tb_wave_mode_ctrl;

  logic       clk = 1'b0, n_rst = 1'b0, key = 1'b0, zc = 1'b0;
  logic [1:0] wave_sel, wave2;
  logic       mute, strobe, busy, mute2, strobe2, busy2;

  int n_chk = 0, n_pass = 0;
  int mute_cyc = 0, strobe_cnt = 0, strobe2_cnt = 0, mb_diff = 0, falls = 0, falls2 = 0, nz_cyc = 0;
  logic       mute_q = 1'b0, mute2_q = 1'b0;
  logic [1:0] strobe_wave[$];

  always #5 clk = ~clk;

  wave_mode_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8), .SETTLE_CYCLES(3)) u_dut (
    .clk(clk), .n_rst(n_rst), .mode_key_raw(key), .zero_cross(zc),
    .wave_sel(wave_sel), .mute(mute), .cfg_strobe(strobe), .busy(busy));

  wave_mode_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32), .SETTLE_CYCLES(3)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .mode_key_raw(key), .zero_cross(zc),
    .wave_sel(wave2), .mute(mute2), .cfg_strobe(strobe2), .busy(busy2));

  always @(negedge clk) begin
    mute_q  <= mute;
    mute2_q <= mute2;
    if (n_rst) begin
      mute_cyc    <= mute_cyc + int'(mute);
      strobe_cnt  <= strobe_cnt + int'(strobe);
      strobe2_cnt <= strobe2_cnt + int'(strobe2);
      mb_diff     <= mb_diff + int'(mute != busy) + int'(mute2 != busy2);
      falls       <= falls + int'(mute_q && !mute);
      falls2      <= falls2 + int'(mute2_q && !mute2);
      nz_cyc      <= nz_cyc + int'(wave_sel != 2'd0 || mute || strobe || busy);
      if (strobe) strobe_wave.push_back(wave_sel);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int hi, input int lo);
    key = 1'b1; cyc(hi);
    key = 1'b0; cyc(lo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; key = 1'b0; zc = 1'b0;
    cyc(3);
    n_rst = 1'b1;
    cyc(2);
  endtask

  task automatic wait_mute(input string tag);
    int t = 0;
    while (!mute && t < 30) begin cyc(1); t++; end
    chk(tag, int'(mute), 1);
  endtask

  initial begin
    int bm, bs, bs2, bf, bf2, bd, qn, n;

    // Reset values and quiet idle
    cyc(3);
    chk("rst_wave", int'(wave_sel), 0);
    chk("rst_mute", int'(mute), 0);
    chk("rst_strobe", int'(strobe), 0);
    chk("rst_busy", int'(busy), 0);
    n_rst = 1'b1;
    bm = nz_cyc;
    cyc(50);
    chk("idle_quiet", nz_cyc - bm, 0);

    // Held key with zero_cross tied high: one 5-cycle change
    do_reset(); zc = 1'b1;
    bm = mute_cyc; bs = strobe_cnt; bd = mb_diff; qn = strobe_wave.size();
    press_key(20, 20); cyc(5);
    chk("held_mute_cyc", mute_cyc - bm, 5);
    chk("held_strobes", strobe_cnt - bs, 1);
    chk("held_wave", int'(wave_sel), 1);
    chk("held_mute_busy", mb_diff - bd, 0);
    chk("held_strobe_wave", (strobe_wave.size() > qn) ? int'(strobe_wave[qn]) : -1, 1);

    // Bouncing key never settles long enough
    do_reset(); zc = 1'b1;
    bm = mute_cyc; bs = strobe_cnt;
    for (int i = 0; i < 15; i++) begin key = ~key; cyc(2); end
    key = 1'b0; cyc(20);
    chk("bounce_mute", mute_cyc - bm, 0);
    chk("bounce_strobe", strobe_cnt - bs, 0);
    chk("bounce_wave", int'(wave_sel), 0);

    // No zero crossing: fade ends on timeout
    do_reset(); zc = 1'b0;
    bm = mute_cyc;
    key = 1'b1;
    wait_mute("to_mute_seen");
    n = 0;
    while (!strobe && n < 30) begin cyc(1); n++; end
    chk("to_fade_plus_update", n, 9);
    key = 1'b0; cyc(20);
    chk("to_mute_cyc", mute_cyc - bm, 12);
    chk("to_wave", int'(wave_sel), 1);

    // Four separate presses walk the full wave cycle
    do_reset(); zc = 1'b1;
    bs = strobe_cnt; qn = strobe_wave.size();
    repeat (4) press_key(8, 12);
    cyc(5);
    chk("seq_strobes", strobe_cnt - bs, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("seq_wave%0d", i),
          (strobe_wave.size() > qn + i) ? int'(strobe_wave[qn + i]) : -1, (i + 1) % 4);

    // Presses during a change: queued and chained without unmuting
    do_reset(); zc = 1'b0;
    bs = strobe_cnt; bs2 = strobe2_cnt; bf = falls; bf2 = falls2; bd = mb_diff;
    repeat (3) press_key(5, 5);
    cyc(80);
    chk("pend_wave", int'(wave_sel), 3);
    chk("pend_strobes", strobe_cnt - bs, 3);
    chk("pend_mute_falls", falls - bf, 1);
    chk("pend_drop_wave", int'(wave2), 2);
    chk("pend_drop_strobes", strobe2_cnt - bs2, 2);
    chk("pend_drop_mute_falls", falls2 - bf2, 1);
    chk("pend_mute_busy", mb_diff - bd, 0);

    // Reset in the middle of a fade aborts it
    do_reset(); zc = 1'b0;
    key = 1'b1;
    wait_mute("abort_mute_seen");
    cyc(3);
    n_rst = 1'b0;
    #1;
    chk("abort_wave", int'(wave_sel), 0);
    chk("abort_mute", int'(mute), 0);
    chk("abort_strobe", int'(strobe), 0);
    chk("abort_busy", int'(busy), 0);
    key = 1'b0;
    cyc(3);
    n_rst = 1'b1;
    cyc(10);
    zc = 1'b1;
    bs = strobe_cnt;
    press_key(8, 12); cyc(5);
    chk("abort_after_wave", int'(wave_sel), 1);
    chk("abort_after_strobes", strobe_cnt - bs, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
